// File: rtl/ir_prep.sv
// ir_prep: conditions raw left/right IR ADC samples for the IR fusion math.
// It box-car averages each side 4:1, decides a debounced open/closed wall
// state per side with hysteresis, and forms a saturated derivative term from
// the left/right difference against a short history of past differences.
module ir_prep #(
    parameter logic [11:0] OPN_THRESH = 12'h600,
    parameter logic [11:0] OPN_HYST   = 12'h040,
    parameter int          DBNC       = 4,
    parameter int          DLY        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smpl_vld,
    input  logic [11:0]       lft_raw,
    input  logic [11:0]       rght_raw,
    output logic [11:0]       lft_IR,
    output logic [11:0]       rght_IR,
    output logic              lft_opn,
    output logic              rght_opn,
    output logic signed [8:0] IR_Dtrm,
    output logic              ir_vld
);

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } opn_state_t;

    // Closing needs a reading clear of the hysteresis band; 13 bits so the
    // threshold sum cannot wrap.
    localparam logic [12:0] CLOSE_LVL = {1'b0, OPN_THRESH} + {1'b0, OPN_HYST};
    localparam logic [3:0]  DBNC_CNT  = 4'(DBNC);
    localparam logic [3:0]  DLY_CNT   = 4'(DLY);

    // Index 0 is the left side, index 1 the right side.
    logic [11:0]        raw       [2];
    logic [13:0]        acc       [2];
    logic [13:0]        sum       [2];
    logic [11:0]        avg       [2];
    logic [1:0]         smpl_cnt;
    logic               update;

    opn_state_t         opn_state [2];
    opn_state_t         nxt_state [2];
    logic [3:0]         dcnt      [2];
    logic [3:0]         nxt_dcnt  [2];
    logic               qual      [2];

    logic signed [12:0] hist      [DLY];
    logic [3:0]         fill;
    logic signed [12:0] diff;
    logic signed [13:0] delta;
    logic signed [13:0] q;
    logic signed [8:0]  dtrm_nxt;

    assign raw[0] = lft_raw;
    assign raw[1] = rght_raw;

    // Running sums and the truncated average that the 4th sample completes.
    always_comb begin
        update = smpl_vld && (smpl_cnt == 2'd3);
        for (int s = 0; s < 2; s++) begin
            sum[s] = acc[s] + {2'b00, raw[s]};
            avg[s] = sum[s][13:2];
        end
    end

    // Accumulate four samples per side, then publish the averages with a
    // one-cycle valid pulse and start the next block from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smpl_cnt <= 2'd0;
            acc[0]   <= '0;
            acc[1]   <= '0;
            lft_IR   <= '0;
            rght_IR  <= '0;
            ir_vld   <= 1'b0;
        end else begin
            ir_vld <= 1'b0;
            if (smpl_vld) begin
                if (smpl_cnt == 2'd3) begin
                    lft_IR   <= avg[0];
                    rght_IR  <= avg[1];
                    acc[0]   <= '0;
                    acc[1]   <= '0;
                    smpl_cnt <= 2'd0;
                    ir_vld   <= 1'b1;
                end else begin
                    acc[0]   <= sum[0];
                    acc[1]   <= sum[1];
                    smpl_cnt <= smpl_cnt + 2'd1;
                end
            end
        end
    end

    // Open/closed decision per side: a run of DBNC qualifying averages flips
    // the state; anything else, including the hysteresis band, restarts it.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nxt_state[s] = opn_state[s];
            nxt_dcnt[s]  = dcnt[s];
            if (opn_state[s] == CLOSED) begin
                qual[s] = (avg[s] < OPN_THRESH);
            end else begin
                qual[s] = ({1'b0, avg[s]} > CLOSE_LVL);
            end
            if (update) begin
                if (qual[s]) begin
                    if ((dcnt[s] + 4'd1) == DBNC_CNT) begin
                        if (opn_state[s] == CLOSED) begin
                            nxt_state[s] = OPEN;
                        end else begin
                            nxt_state[s] = CLOSED;
                        end
                        nxt_dcnt[s] = 4'd0;
                    end else begin
                        nxt_dcnt[s] = dcnt[s] + 4'd1;
                    end
                end else begin
                    nxt_dcnt[s] = 4'd0;
                end
            end
        end
    end

    // Open-detection state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                opn_state[s] <= CLOSED;
                dcnt[s]      <= 4'd0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                opn_state[s] <= nxt_state[s];
                dcnt[s]      <= nxt_dcnt[s];
            end
        end
    end

    assign lft_opn  = (opn_state[0] == OPEN);
    assign rght_opn = (opn_state[1] == OPEN);

    // Derivative: change of the left/right difference over DLY updates,
    // scaled by 1/4 and clamped to 9 bits; suppressed until the history is
    // full and whenever either side is seeing an open wall.
    always_comb begin
        diff     = $signed({1'b0, avg[0]}) - $signed({1'b0, avg[1]});
        delta    = $signed({diff[12], diff}) - $signed({hist[DLY-1][12], hist[DLY-1]});
        q        = delta >>> 2;
        dtrm_nxt = '0;
        if ((fill >= DLY_CNT) && (nxt_state[0] != OPEN) && (nxt_state[1] != OPEN)) begin
            if (q > 14'sd255) begin
                dtrm_nxt = 9'sh0FF;
            end else if (q < -14'sd256) begin
                dtrm_nxt = 9'sh100;
            end else begin
                dtrm_nxt = q[8:0];
            end
        end
    end

    // Difference history, fill count and the registered derivative output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) begin
                hist[i] <= '0;
            end
            fill    <= 4'd0;
            IR_Dtrm <= '0;
        end else if (update) begin
            hist[0] <= diff;
            for (int i = 1; i < DLY; i++) begin
                hist[i] <= hist[i-1];
            end
            if (fill < DLY_CNT) begin
                fill <= fill + 4'd1;
            end
            IR_Dtrm <= dtrm_nxt;
        end
    end

endmodule
